writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final pipeline stage of the MIPS core, between the memory stage and the register file / coprocessor0.
- Holds one retiring instruction in a valid/allow-in pipeline register.
- Writes the GPR result and drives the WB-to-CP0 bus for MTC0, MFC0, ERET and exception commit.
- Raises a flush request with a redirect target when an exception or ERET retires.

Parameters:
- CPU_DATA_WIDTH, 32, datapath and PC width.
- REG_ADDR_WIDTH, 5, GPR index width.
- EXCEPTION_ENTRY, 32'hBFC00380, redirect PC on exception commit.

Ports:
- clock  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- mem_to_wb_valid  in  1  memory stage presents an instruction.
- mem_to_wb_bus  in  struct MemToWBData  pc, dest, result, reg_write, mtc0, mfc0, eret, exception_valid, exception_code[4:0], in_delay_slot, cp0_register[4:0], cp0_select[2:0].
- wb_allow_in  out  1  stage can accept an instruction this cycle.
- cp0_read_data  in  CPU_DATA_WIDTH  combinational CP0 read for the addressed register.
- wb_to_cp0_data_bus  out  struct WBToCP0Data  write_enabled, address_register, address_select, write_data, exception_valid, exception_code, in_delay_slot, exception_pc, eret_flush.
- cp0_epc  in  CPU_DATA_WIDTH  current EPC, used as the ERET target.
- rf_write_enable  out  1  GPR write strobe.
- rf_write_address  out  REG_ADDR_WIDTH  GPR destination.
- rf_write_data  out  CPU_DATA_WIDTH  GPR data.
- wb_forward_bus  out  struct WBForwardData  valid, dest, data, for decode-stage bypass/interlock.
- flush  out  1  kill all younger instructions this cycle.
- flush_target  out  CPU_DATA_WIDTH  fetch redirect PC, valid only while flush=1.

Behaviour:
- Handshake:
  - wb_ready_go = 1; wb_allow_in = !wb_valid | wb_ready_go.
  - Load on a rising edge when wb_allow_in & mem_to_wb_valid & !flush.
  - Otherwise wb_valid <= 0 when wb_allow_in.
- Reset (reset=0, asynchronous):
  - wb_valid=0; the stored bus is cleared to zero.
  - All outputs are therefore 0: rf_write_enable, flush, every write strobe, eret_flush, exception_valid.
- Latency: an instruction accepted at edge N drives its writes during cycle N+1; the register file and CP0 capture them at edge N+1.
- Commit gating: every side effect requires wb_valid.
  - An exception also suppresses rf_write_enable and the CP0 write.
  - exception_valid takes priority over eret and mtc0 in the same instruction.
- GPR write:
  - rf_write_enable = wb_valid & reg_write & !exception_valid & (dest != 0).
  - rf_write_data = mfc0 ? cp0_read_data : result.
- CP0 bus:
  - address_register/address_select come from the stored cp0 fields.
  - write_enabled = wb_valid & mtc0 & !exception_valid.
  - write_data = result (rt value).
  - exception_pc = in_delay_slot ? pc-4 : pc.
  - eret_flush = wb_valid & eret & !exception_valid.
- Flush:
  - flush = wb_valid & (exception_valid | eret), combinational.
  - flush_target = exception_valid ? EXCEPTION_ENTRY : cp0_epc.
  - An instruction offered by the memory stage in the flush cycle is dropped, never latched.
- Forward bus: valid = rf_write_enable; dest and data mirror the GPR write.
- Simultaneous events:
  - MFC0 reading a register written by the preceding MTC0 sees the new value, because CP0 updated at the previous edge.
  - Back-to-back accepts with no bubble are supported.
- Reset mid-operation: the pending instruction is discarded with no write; the first post-reset accept behaves as from idle.

Decomposition:
- coprocessor0_params package: WBToCP0Data (already used by coprocessor0), exception code constants.
- cpu_core_params package: MemToWBData, WBForwardData, CpuData, CPU_DATA_WIDTH.
- No sub-module; the pipeline register and gating are inline.

Test Plan:
- Reset 0 mid-instruction, then release:
  - All outputs 0 immediately.
  - An ADDU to $5 = 0x1234 then retires: rf_write_enable=1, address 5, data 0x1234, one cycle after accept.
- MTC0 $12 sel0 with data 0x0000FF01 -> write_enabled=1, address_register 12, write_data 0x0000FF01.
- MFC0 to $3 the next cycle -> rf_write_data equals cp0_read_data (0x0040FF01 with BEV set).
- Syscall (code 8) at pc 0xBFC00100, in_delay_slot=1:
  - exception_valid=1, exception_pc 0xBFC000FC.
  - flush=1, flush_target 0xBFC00380, no GPR write.
  - The memory stage's simultaneous valid is dropped (wb_valid=0 next cycle).
- ERET with cp0_epc 0xBFC00200 -> eret_flush=1, flush=1, flush_target 0xBFC00200.
- Write to $0 with reg_write=1 -> rf_write_enable=0, forward valid=0.
- Continuous stream of 8 ALU ops -> wb_allow_in stays 1 and one GPR write per cycle.

Source files
------------

// File: rtl/coprocessor0_params.sv
// Coprocessor0 interface formats and exception code constants.
package coprocessor0_params;

    localparam int CP0_DATA_WIDTH = 32;

    // ExcCode values as written into Cause.ExcCode.
    localparam logic [4:0] EXC_INTERRUPT      = 5'd0;
    localparam logic [4:0] EXC_ADDRESS_LOAD   = 5'd4;
    localparam logic [4:0] EXC_ADDRESS_STORE  = 5'd5;
    localparam logic [4:0] EXC_SYSCALL        = 5'd8;
    localparam logic [4:0] EXC_BREAKPOINT     = 5'd9;
    localparam logic [4:0] EXC_RESERVED_INSTR = 5'd10;
    localparam logic [4:0] EXC_OVERFLOW       = 5'd12;

    // Commit information presented by writeback to coprocessor0.
    typedef struct packed {
        logic                      write_enabled;
        logic [4:0]                address_register;
        logic [2:0]                address_select;
        logic [CP0_DATA_WIDTH-1:0] write_data;
        logic                      exception_valid;
        logic [4:0]                exception_code;
        logic                      in_delay_slot;
        logic [CP0_DATA_WIDTH-1:0] exception_pc;
        logic                      eret_flush;
    } WBToCP0Data;

    // EPC for a faulting instruction: branch address when it sits in a delay slot.
    function automatic logic [CP0_DATA_WIDTH-1:0] exception_epc(
        input logic [CP0_DATA_WIDTH-1:0] pc,
        input logic                      in_delay_slot
    );
        return in_delay_slot ? (pc - CP0_DATA_WIDTH'(4)) : pc;
    endfunction

endpackage

// File: rtl/cpu_core_params.sv
// Core-wide datapath constants and the inter-stage bus formats used around
// the writeback stage.
package cpu_core_params;

    localparam int CPU_DATA_WIDTH = 32;
    localparam int REG_ADDR_WIDTH = 5;

    typedef logic [CPU_DATA_WIDTH-1:0] CpuData;
    typedef logic [REG_ADDR_WIDTH-1:0] RegAddr;

    // Instruction retiring out of the memory stage.
    typedef struct packed {
        CpuData     pc;
        RegAddr     dest;
        CpuData     result;
        logic       reg_write;
        logic       mtc0;
        logic       mfc0;
        logic       eret;
        logic       exception_valid;
        logic [4:0] exception_code;
        logic       in_delay_slot;
        logic [4:0] cp0_register;
        logic [2:0] cp0_select;
    } MemToWBData;

    // Bypass/interlock information for the decode stage.
    typedef struct packed {
        logic   valid;
        RegAddr dest;
        CpuData data;
    } WBForwardData;

endpackage

// File: rtl/writeback_stage.sv
// Writeback stage: holds the retiring instruction, commits the GPR write,
// drives the coprocessor0 commit bus and raises a flush on exception/ERET.
module writeback_stage
    import cpu_core_params::MemToWBData;
    import cpu_core_params::WBForwardData;
    import coprocessor0_params::WBToCP0Data;
    import coprocessor0_params::exception_epc;
#(
    parameter int                        CPU_DATA_WIDTH  = 32,
    parameter int                        REG_ADDR_WIDTH  = 5,
    parameter logic [CPU_DATA_WIDTH-1:0] EXCEPTION_ENTRY = 32'hBFC00380
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      mem_to_wb_valid,
    input  MemToWBData                mem_to_wb_bus,
    output logic                      wb_allow_in,
    input  logic [CPU_DATA_WIDTH-1:0] cp0_read_data,
    output WBToCP0Data                wb_to_cp0_data_bus,
    input  logic [CPU_DATA_WIDTH-1:0] cp0_epc,
    output logic                      rf_write_enable,
    output logic [REG_ADDR_WIDTH-1:0] rf_write_address,
    output logic [CPU_DATA_WIDTH-1:0] rf_write_data,
    output WBForwardData              wb_forward_bus,
    output logic                      flush,
    output logic [CPU_DATA_WIDTH-1:0] flush_target
);

    logic       wb_valid;
    logic       wb_ready_go;
    MemToWBData wb_data;
    logic       commit_exception;
    logic       commit_eret;

    // Writeback always completes in one cycle, so the stage never stalls.
    assign wb_ready_go = 1'b1;
    assign wb_allow_in = !wb_valid || wb_ready_go;

    // Pipeline register; an instruction offered while we flush is younger
    // than the faulting one and must be dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_valid <= 1'b0;
            wb_data  <= '0;
        end else if (wb_allow_in) begin
            if (mem_to_wb_valid && !flush) begin
                wb_valid <= 1'b1;
                wb_data  <= mem_to_wb_bus;
            end else begin
                wb_valid <= 1'b0;
            end
        end
    end

    // An exception outranks everything else the same instruction asks for.
    always_comb begin
        commit_exception = wb_valid && wb_data.exception_valid;
        commit_eret      = wb_valid && wb_data.eret && !wb_data.exception_valid;
    end

    // GPR write and the matching bypass information.
    always_comb begin
        rf_write_enable  = wb_valid && wb_data.reg_write && !wb_data.exception_valid
                           && (wb_data.dest != '0);
        rf_write_address = wb_data.dest;
        rf_write_data    = wb_data.mfc0 ? cp0_read_data : wb_data.result;

        wb_forward_bus.valid = rf_write_enable;
        wb_forward_bus.dest  = rf_write_address;
        wb_forward_bus.data  = rf_write_data;
    end

    // Coprocessor0 commit bus: MTC0 write, exception record and ERET.
    always_comb begin
        wb_to_cp0_data_bus.write_enabled    = wb_valid && wb_data.mtc0 && !wb_data.exception_valid;
        wb_to_cp0_data_bus.address_register = wb_data.cp0_register;
        wb_to_cp0_data_bus.address_select   = wb_data.cp0_select;
        wb_to_cp0_data_bus.write_data       = wb_data.result;
        wb_to_cp0_data_bus.exception_valid  = commit_exception;
        wb_to_cp0_data_bus.exception_code   = wb_data.exception_code;
        wb_to_cp0_data_bus.in_delay_slot    = wb_data.in_delay_slot;
        wb_to_cp0_data_bus.exception_pc     = exception_epc(wb_data.pc, wb_data.in_delay_slot);
        wb_to_cp0_data_bus.eret_flush       = commit_eret;
    end

    // Redirect fetch to the handler on an exception, or back to EPC on ERET.
    always_comb begin
        flush        = commit_exception || commit_eret;
        flush_target = wb_data.exception_valid ? EXCEPTION_ENTRY : cp0_epc;
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_writeback_stage;
    import cpu_core_params::*;
    import coprocessor0_params::*;

    localparam logic [31:0] EXC_ENTRY = 32'hBFC00380;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         mem_to_wb_valid = 1'b0;
    MemToWBData   mem_to_wb_bus = '0;
    logic         wb_allow_in;
    logic [31:0]  cp0_read_data = '0;
    WBToCP0Data   wb_to_cp0_data_bus;
    logic [31:0]  cp0_epc = '0;
    logic         rf_write_enable;
    logic [4:0]   rf_write_address;
    logic [31:0]  rf_write_data;
    WBForwardData wb_forward_bus;
    logic         flush;
    logic [31:0]  flush_target;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    writeback_stage #(
        .CPU_DATA_WIDTH (32),
        .REG_ADDR_WIDTH (5),
        .EXCEPTION_ENTRY(EXC_ENTRY)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .mem_to_wb_valid   (mem_to_wb_valid),
        .mem_to_wb_bus     (mem_to_wb_bus),
        .wb_allow_in       (wb_allow_in),
        .cp0_read_data     (cp0_read_data),
        .wb_to_cp0_data_bus(wb_to_cp0_data_bus),
        .cp0_epc           (cp0_epc),
        .rf_write_enable   (rf_write_enable),
        .rf_write_address  (rf_write_address),
        .rf_write_data     (rf_write_data),
        .wb_forward_bus    (wb_forward_bus),
        .flush             (flush),
        .flush_target      (flush_target)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // The retiring instruction as last accepted, and whether it is live.
    logic       m_valid = 1'b0;
    MemToWBData m_instr = '0;

    // Apply the acceptance rule at a rising edge using the inputs held across it.
    task automatic model_edge();
        logic killing;
        killing = m_valid && (m_instr.exception_valid || m_instr.eret);
        if (mem_to_wb_valid && !killing) begin
            m_valid = 1'b1;
            m_instr = mem_to_wb_bus;
        end else begin
            m_valid = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_instr = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset) model_edge();
        else model_reset();
        #1;
    endtask

    // Compare every observable output against what the model says must retire.
    task automatic check_model();
        logic        e_we, e_flush, e_cp0_we, e_exc, e_eret;
        logic [31:0] e_data, e_epc;
        e_exc    = m_valid && m_instr.exception_valid;
        e_eret   = m_valid && m_instr.eret && !m_instr.exception_valid;
        e_we     = m_valid && m_instr.reg_write && !m_instr.exception_valid && (m_instr.dest != 5'd0);
        e_cp0_we = m_valid && m_instr.mtc0 && !m_instr.exception_valid;
        e_flush  = m_valid && (m_instr.exception_valid || m_instr.eret);
        e_data   = m_instr.mfc0 ? cp0_read_data : m_instr.result;
        e_epc    = m_instr.in_delay_slot ? m_instr.pc - 32'd4 : m_instr.pc;
        check("rnd_allow_in", wb_allow_in, 1'b1);
        check("rnd_rf_we", rf_write_enable, e_we);
        check("rnd_fwd_valid", wb_forward_bus.valid, e_we);
        if (e_we) begin
            check("rnd_rf_addr", rf_write_address, m_instr.dest);
            check("rnd_rf_data", rf_write_data, e_data);
            check("rnd_fwd_dest", wb_forward_bus.dest, m_instr.dest);
            check("rnd_fwd_data", wb_forward_bus.data, e_data);
        end
        check("rnd_flush", flush, e_flush);
        if (e_flush)
            check("rnd_flush_target", flush_target, m_instr.exception_valid ? EXC_ENTRY : cp0_epc);
        check("rnd_cp0_we", wb_to_cp0_data_bus.write_enabled, e_cp0_we);
        check("rnd_cp0_exc", wb_to_cp0_data_bus.exception_valid, e_exc);
        check("rnd_cp0_eret", wb_to_cp0_data_bus.eret_flush, e_eret);
        if (m_valid) begin
            check("rnd_cp0_reg", wb_to_cp0_data_bus.address_register, m_instr.cp0_register);
            check("rnd_cp0_sel", wb_to_cp0_data_bus.address_select, m_instr.cp0_select);
            check("rnd_cp0_wdata", wb_to_cp0_data_bus.write_data, m_instr.result);
            check("rnd_cp0_code", wb_to_cp0_data_bus.exception_code, m_instr.exception_code);
            check("rnd_cp0_ds", wb_to_cp0_data_bus.in_delay_slot, m_instr.in_delay_slot);
            check("rnd_cp0_epc", wb_to_cp0_data_bus.exception_pc, e_epc);
        end
    endtask

    task automatic check_all_quiet(input string tag);
        check({tag, "_rf_we"}, rf_write_enable, 1'b0);
        check({tag, "_flush"}, flush, 1'b0);
        check({tag, "_cp0_we"}, wb_to_cp0_data_bus.write_enabled, 1'b0);
        check({tag, "_eret"}, wb_to_cp0_data_bus.eret_flush, 1'b0);
        check({tag, "_exc"}, wb_to_cp0_data_bus.exception_valid, 1'b0);
        check({tag, "_fwd_valid"}, wb_forward_bus.valid, 1'b0);
    endtask

    function automatic MemToWBData alu_op(input logic [4:0] dest, input logic [31:0] result,
                                          input logic [31:0] pc);
        MemToWBData d;
        d = '0;
        d.pc        = pc;
        d.dest      = dest;
        d.result    = result;
        d.reg_write = 1'b1;
        return d;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        string       name;
        MemToWBData  instr;
        logic [31:0] cp0_rd;
        logic [31:0] epc;
        logic        e_rf_we;
        logic [4:0]  e_rf_addr;
        logic [31:0] e_rf_data;
        logic        e_flush;
        logic [31:0] e_target;
        logic        e_cp0_we;
        logic        e_eret;
        logic        e_exc;
        logic [31:0] e_exc_pc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        MemToWBData d;

        // ADDU $7
        d = alu_op(5'd7, 32'hDEADBEEF, 32'hBFC00000);
        vecs[0] = '{"addu", d, 32'h0, 32'h0, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'hBFC00000};
        // MTC0 $12 sel0
        d = '0; d.pc = 32'hBFC00004; d.mtc0 = 1'b1; d.cp0_register = 5'd12; d.result = 32'h0000FF01;
        vecs[1] = '{"mtc0", d, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'hBFC00004};
        // MFC0 $3 <- Status
        d = alu_op(5'd3, 32'h00000055, 32'hBFC00008); d.mfc0 = 1'b1; d.cp0_register = 5'd12;
        vecs[2] = '{"mfc0", d, 32'h0040FF01, 32'h0, 1'b1, 5'd3, 32'h0040FF01, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'hBFC00008};
        // SYSCALL in a delay slot
        d = alu_op(5'd4, 32'h11111111, 32'hBFC00100); d.exception_valid = 1'b1;
        d.exception_code = EXC_SYSCALL; d.in_delay_slot = 1'b1;
        vecs[3] = '{"syscall", d, 32'h0, 32'h12345678, 1'b0, 5'd0, 32'h0, 1'b1, 32'hBFC00380, 1'b0, 1'b0, 1'b1, 32'hBFC000FC};
        // ERET
        d = '0; d.pc = 32'hBFC00300; d.eret = 1'b1;
        vecs[4] = '{"eret", d, 32'h0, 32'hBFC00200, 1'b0, 5'd0, 32'h0, 1'b1, 32'hBFC00200, 1'b0, 1'b1, 1'b0, 32'hBFC00300};
        // write to $0
        d = alu_op(5'd0, 32'hCAFEF00D, 32'hBFC00010);
        vecs[5] = '{"zero_dest", d, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'hBFC00010};
        // exception together with eret and mtc0: exception wins
        d = alu_op(5'd9, 32'h7FFFFFFF, 32'h80001000); d.exception_valid = 1'b1;
        d.exception_code = EXC_OVERFLOW; d.eret = 1'b1; d.mtc0 = 1'b1;
        vecs[6] = '{"exc_prio", d, 32'h0, 32'hBFC00200, 1'b0, 5'd0, 32'h0, 1'b1, 32'hBFC00380, 1'b0, 1'b0, 1'b1, 32'h80001000};
        // MFC0 to $31
        d = alu_op(5'd31, 32'h0, 32'hBFC00020); d.mfc0 = 1'b1; d.cp0_register = 5'd14;
        vecs[7] = '{"mfc0_r31", d, 32'hA5A5A5A5, 32'h0, 1'b1, 5'd31, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'hBFC00020};
    end

    // ---------------- test sequence ----------------
    initial begin
        MemToWBData d;
        int errs_before;

        // Power-on reset
        reset = 1'b0;
        #1;
        check_all_quiet("por");
        check("por_allow_in", wb_allow_in, 1'b1);
        repeat (2) tick();
        reset = 1'b1;
        $display("reset released");

        // Reset while an instruction is held, then a clean retirement.
        mem_to_wb_valid = 1'b1;
        mem_to_wb_bus   = alu_op(5'd6, 32'h00000666, 32'hBFC00000);
        tick();
        mem_to_wb_valid = 1'b0;
        check("pre_reset_rf_we", rf_write_enable, 1'b1);
        reset = 1'b0;
        model_reset();
        #1;
        check_all_quiet("midreset");
        tick();
        reset = 1'b1;
        mem_to_wb_valid = 1'b1;
        mem_to_wb_bus   = alu_op(5'd5, 32'h00001234, 32'hBFC00004);
        tick();
        mem_to_wb_valid = 1'b0;
        #1;
        check("post_reset_rf_we", rf_write_enable, 1'b1);
        check("post_reset_rf_addr", rf_write_address, 5'd5);
        check("post_reset_rf_data", rf_write_data, 32'h00001234);
        $display("reset mid-instruction then ADDU $5 retired");
        tick();

        // Table of single instructions, each followed by a bubble.
        for (int i = 0; i < 8; i++) begin
            errs_before = errors;
            mem_to_wb_valid = 1'b1;
            mem_to_wb_bus   = vecs[i].instr;
            tick();
            mem_to_wb_valid = 1'b0;
            cp0_read_data   = vecs[i].cp0_rd;
            cp0_epc         = vecs[i].epc;
            #1;
            check({vecs[i].name, "_rf_we"}, rf_write_enable, vecs[i].e_rf_we);
            check({vecs[i].name, "_fwd_valid"}, wb_forward_bus.valid, vecs[i].e_rf_we);
            if (vecs[i].e_rf_we) begin
                check({vecs[i].name, "_rf_addr"}, rf_write_address, vecs[i].e_rf_addr);
                check({vecs[i].name, "_rf_data"}, rf_write_data, vecs[i].e_rf_data);
            end
            check({vecs[i].name, "_flush"}, flush, vecs[i].e_flush);
            if (vecs[i].e_flush)
                check({vecs[i].name, "_target"}, flush_target, vecs[i].e_target);
            check({vecs[i].name, "_cp0_we"}, wb_to_cp0_data_bus.write_enabled, vecs[i].e_cp0_we);
            check({vecs[i].name, "_eret"}, wb_to_cp0_data_bus.eret_flush, vecs[i].e_eret);
            check({vecs[i].name, "_exc"}, wb_to_cp0_data_bus.exception_valid, vecs[i].e_exc);
            check({vecs[i].name, "_exc_pc"}, wb_to_cp0_data_bus.exception_pc, vecs[i].e_exc_pc);
            if (vecs[i].e_cp0_we) begin
                check({vecs[i].name, "_cp0_reg"}, wb_to_cp0_data_bus.address_register, vecs[i].instr.cp0_register);
                check({vecs[i].name, "_cp0_wdata"}, wb_to_cp0_data_bus.write_data, vecs[i].instr.result);
            end
            if (vecs[i].e_exc)
                check({vecs[i].name, "_exc_code"}, wb_to_cp0_data_bus.exception_code, vecs[i].instr.exception_code);
            $display("vector %0d %s errors_added=%0d", i, vecs[i].name, errors - errs_before);
            tick();
        end

        // MTC0 Status immediately followed by MFC0 Status.
        d = '0; d.mtc0 = 1'b1; d.cp0_register = 5'd12; d.result = 32'h0000FF01;
        mem_to_wb_valid = 1'b1;
        mem_to_wb_bus   = d;
        tick();
        d = alu_op(5'd3, 32'h0, 32'hBFC00040); d.mfc0 = 1'b1; d.cp0_register = 5'd12;
        mem_to_wb_bus = d;
        #1;
        check("b2b_mtc0_we", wb_to_cp0_data_bus.write_enabled, 1'b1);
        check("b2b_mtc0_reg", wb_to_cp0_data_bus.address_register, 5'd12);
        check("b2b_mtc0_sel", wb_to_cp0_data_bus.address_select, 3'd0);
        check("b2b_mtc0_data", wb_to_cp0_data_bus.write_data, 32'h0000FF01);
        tick();
        mem_to_wb_valid = 1'b0;
        cp0_read_data   = 32'h0040FF01;
        #1;
        check("b2b_mfc0_we", rf_write_enable, 1'b1);
        check("b2b_mfc0_addr", rf_write_address, 5'd3);
        check("b2b_mfc0_data", rf_write_data, 32'h0040FF01);
        $display("MTC0 then MFC0 back-to-back");
        tick();

        // SYSCALL retiring while the memory stage offers a younger ADDU.
        d = alu_op(5'd4, 32'h0, 32'hBFC00100); d.exception_valid = 1'b1;
        d.exception_code = EXC_SYSCALL; d.in_delay_slot = 1'b1;
        mem_to_wb_valid = 1'b1;
        mem_to_wb_bus   = d;
        tick();
        mem_to_wb_bus = alu_op(5'd9, 32'h99999999, 32'hBFC00104);
        #1;
        check("sys_flush", flush, 1'b1);
        check("sys_target", flush_target, 32'hBFC00380);
        check("sys_exc_pc", wb_to_cp0_data_bus.exception_pc, 32'hBFC000FC);
        check("sys_rf_we", rf_write_enable, 1'b0);
        tick();
        mem_to_wb_valid = 1'b0;
        #1;
        check("sys_dropped_rf_we", rf_write_enable, 1'b0);
        check("sys_dropped_flush", flush, 1'b0);
        $display("SYSCALL flush dropped younger instruction");
        tick();

        // Continuous stream of 8 ALU ops.
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                mem_to_wb_valid = 1'b1;
                mem_to_wb_bus   = alu_op(5'(i + 1), 32'h1000 + 32'(i), 32'hBFC01000 + 32'(4 * i));
            end else begin
                mem_to_wb_valid = 1'b0;
            end
            #1;
            check("stream_allow_in", wb_allow_in, 1'b1);
            if (i > 0) begin
                check("stream_rf_we", rf_write_enable, 1'b1);
                check("stream_rf_addr", rf_write_address, 5'(i));
                check("stream_rf_data", rf_write_data, 32'h1000 + 32'(i - 1));
                $display("stream op %0d retired to $%0d", i - 1, rf_write_address);
            end
            tick();
        end

        // Randomized run against the model.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b0;
                model_reset();
                #1;
                check_all_quiet("rnd_reset");
                reset = 1'b1;
            end
            mem_to_wb_valid = ($urandom_range(0, 3) != 0);
            d = '0;
            d.pc              = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
            d.dest            = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            d.result          = $urandom;
            d.reg_write       = ($urandom_range(0, 3) != 0);
            d.mtc0            = ($urandom_range(0, 3) == 0);
            d.mfc0            = ($urandom_range(0, 3) == 0);
            d.eret            = ($urandom_range(0, 7) == 0);
            d.exception_valid = ($urandom_range(0, 5) == 0);
            d.exception_code  = 5'($urandom);
            d.in_delay_slot   = ($urandom_range(0, 1) == 1);
            d.cp0_register    = 5'($urandom);
            d.cp0_select      = 3'($urandom);
            mem_to_wb_bus = d;
            cp0_read_data = $urandom;
            cp0_epc       = $urandom;
            #1;
            check_model();
            if (m_valid)
                $display("random cycle %0d pc=%08h rf_we=%0d flush=%0d", c, m_instr.pc, rf_write_enable, flush);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard bound so a broken clock or wait can never hang the run.
    initial begin
        #200000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
